// File: rtl/qpmm_stream_ctrl_if.sv
// Operand-in / result-out stream bundle for the QPMM issue/collect controller.
// master drives operands and consumes results; slave is the controller side.
interface qpmm_stream_ctrl_if #(
    parameter int A_W = 288,
    parameter int Z_W = 398
);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_a;
    logic [A_W-1:0] in_b;
    logic           out_valid;
    logic           out_ready;
    logic [Z_W-1:0] out_z;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/qpmm_stream_ctrl.sv
// Issue/collect controller around the fixed-latency QPMM multiplier: valid-tag
// delay line, FWFT result FIFO and issue-to-consume credit accounting.
module qpmm_stream_ctrl #(
    parameter int A_W   = 288,
    parameter int Z_W   = 398,
    parameter int LAT   = 82,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rstn,
    qpmm_stream_ctrl_if.slave          st,
    output logic [A_W-1:0]             mul_a,
    output logic [A_W-1:0]             mul_b,
    input  logic [Z_W-1:0]             mul_z,
    output logic [$clog2(DEPTH+1)-1:0] used,
    output logic                       err_overflow
);
    localparam int UW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic           fire;
    logic           pop;
    logic           capture;
    logic           fifo_full;
    logic           wr_en;
    logic           mul_vld;
    logic [LAT-1:0] tag;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [UW-1:0]  count;
    logic [Z_W-1:0] mem [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits are taken at issue, so a full `used` already covers every
    // result still inside the multiplier.
    assign st.in_ready  = rstn & (used < UW'(DEPTH));
    assign fire         = st.in_valid & st.in_ready;
    assign st.out_valid = (count != '0);
    assign pop          = st.out_valid & st.out_ready;
    assign st.out_z     = mem[rd_ptr];

    assign capture   = tag[LAT-1];
    assign fifo_full = (count == UW'(DEPTH));
    assign wr_en     = capture & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_vld <= 1'b0;
        end else begin
            mul_a   <= fire ? st.in_a : '0;
            mul_b   <= fire ? st.in_b : '0;
            mul_vld <= fire;
        end
    end

    // mul_vld qualifies the operand register; tag[LAT-1] then lines up with mul_z.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag <= '0;
        end else begin
            tag[0] <= mul_vld;
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= mul_z;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            used         <= '0;
            err_overflow <= 1'b0;
        end else begin
            case ({fire, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
            // Only reachable if the credit scheme is broken.
            if (capture & fifo_full & ~pop) begin
                err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qpmm_stream_ctrl.sv
// Bench for qpmm_stream_ctrl: multiplier stand-in pipeline, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_qpmm_stream_ctrl;
    localparam int A_W   = 288;
    localparam int Z_W   = 398;
    localparam int LAT   = 82;
    localparam int DEPTH = 128;
    localparam int UW    = $clog2(DEPTH + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    qpmm_stream_ctrl_if #(.A_W(A_W), .Z_W(Z_W)) sif ();
    logic [A_W-1:0] mul_a;
    logic [A_W-1:0] mul_b;
    logic [Z_W-1:0] mul_z;
    logic [UW-1:0]  used;
    logic           err_overflow;

    qpmm_stream_ctrl #(.A_W(A_W), .Z_W(Z_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .st           (sif),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_z        (mul_z),
        .used         (used),
        .err_overflow (err_overflow)
    );

    // Stand-in multiplier: plain product, LAT cycles, never reset, no stall.
    function automatic logic [Z_W-1:0] mfunc(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
        return Z_W'(a) * Z_W'(b);
    endfunction

    logic [Z_W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mfunc(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [Z_W-1:0] act, input logic [Z_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: results due a fixed time after acceptance, queued in order.
    typedef struct {
        logic [Z_W-1:0] z;
        int             due;
    } fl_t;

    fl_t            flight [$];
    logic [Z_W-1:0] outq [$];
    int             m_used = 0;
    int             m_cyc  = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flight.delete();
            outq.delete();
            m_used = 0;
        end else begin
            bit  f;
            bit  p;
            fl_t e;
            m_cyc++;
            f = sif.in_valid && (m_used < DEPTH);
            p = sif.out_ready && (outq.size() > 0);
            if (p) void'(outq.pop_front());
            while (flight.size() > 0 && flight[0].due == m_cyc) begin
                e = flight.pop_front();
                outq.push_back(e.z);
            end
            if (f) begin
                e.z   = mfunc(sif.in_a, sif.in_b);
                e.due = m_cyc + LAT + 1;
                flight.push_back(e);
            end
            m_used = m_used + int'(f) - int'(p);
        end
    end

    int n_pops   = 0;
    int prev_pop = -1;
    int gaps     = 0;

    always @(negedge clk) begin
        chk("in_ready", Z_W'(sif.in_ready), Z_W'(rstn && (m_used < DEPTH)));
        chk("out_valid", Z_W'(sif.out_valid), Z_W'(outq.size() > 0));
        chk("used", Z_W'(used), Z_W'(m_used));
        chk("err_overflow", Z_W'(err_overflow), '0);
        if (outq.size() > 0) chk("out_z", sif.out_z, outq[0]);
        if (rstn && sif.out_valid && sif.out_ready) begin
            n_pops++;
            if (prev_pop >= 0 && m_cyc - prev_pop > 1) gaps++;
            prev_pop = m_cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [A_W-1:0] rnd();
        logic [A_W-1:0] v;
        v = '0;
        for (int i = 0; i < (A_W + 31) / 32; i++) v = {v[A_W-33:0], $urandom()};
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int drops;
        int p0;
        int hi;

        sif.in_valid  = 1'b0;
        sif.in_a      = '0;
        sif.in_b      = '0;
        sif.out_ready = 1'b0;

        // Reset
        repeat (10) step();
        chk("rst_in_ready", Z_W'(sif.in_ready), '0);
        chk("rst_out_valid", Z_W'(sif.out_valid), '0);
        chk("rst_used", Z_W'(used), '0);
        chk("rst_out_z", sif.out_z, '0);
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", Z_W'(sif.in_ready), Z_W'(1));

        // Single op: A=B=1 fired at edge 0
        step();
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        sif.in_a      = A_W'(1);
        sif.in_b      = A_W'(1);
        step();
        sif.in_valid = 1'b0;
        sif.in_a     = '0;
        sif.in_b     = '0;
        chk("single_mul_a", Z_W'(mul_a), Z_W'(1));
        chk("single_used1", Z_W'(used), Z_W'(1));
        n = 1;
        while (!sif.out_valid && n < 200) begin
            step();
            n++;
        end
        chk("single_latency", Z_W'(n), Z_W'(84));
        chk("single_out_z", sif.out_z, Z_W'(1));
        step();
        chk("single_used0", Z_W'(used), '0);
        chk("single_drained", Z_W'(sif.out_valid), '0);

        // Throughput: 1000 back-to-back pairs
        drops    = 0;
        p0       = n_pops;
        prev_pop = -1;
        gaps     = 0;
        for (int i = 0; i < 1000; i++) begin
            sif.in_valid = 1'b1;
            sif.in_a     = rnd();
            sif.in_b     = rnd();
            if (!sif.in_ready) drops++;
            step();
        end
        sif.in_valid = 1'b0;
        repeat (LAT + 10) step();
        chk("tput_in_ready_drops", Z_W'(drops), '0);
        chk("tput_results", Z_W'(n_pops - p0), Z_W'(1000));
        chk("tput_gaps", Z_W'(gaps), '0);

        // Backpressure: 200 offered, consumer stalled
        sif.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            sif.in_valid = 1'b1;
            sif.in_a     = rnd();
            sif.in_b     = rnd();
            if (sif.in_ready) acc++;
            step();
        end
        sif.in_valid = 1'b0;
        chk("bp_accepted", Z_W'(acc), Z_W'(128));
        chk("bp_in_ready", Z_W'(sif.in_ready), '0);
        chk("bp_used", Z_W'(used), Z_W'(128));
        chk("bp_err", Z_W'(err_overflow), '0);
        repeat (LAT + 5) step();
        chk("bp_full_valid", Z_W'(sif.out_valid), Z_W'(1));

        // Full boundary: pop with pending input at used=DEPTH
        sif.in_valid  = 1'b1;
        sif.in_a      = rnd();
        sif.in_b      = rnd();
        sif.out_ready = 1'b1;
        step();
        chk("full_pop_used", Z_W'(used), Z_W'(127));
        chk("full_in_ready_back", Z_W'(sif.in_ready), Z_W'(1));
        step();
        chk("fire_pop_used", Z_W'(used), Z_W'(127));
        sif.in_valid = 1'b0;
        n = 0;
        while (used != 0 && n < 600) begin
            step();
            n++;
        end
        chk("bp_drain_used", Z_W'(used), '0);

        // Mid-stream reset
        sif.out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sif.in_valid = 1'b1;
            sif.in_a     = rnd();
            sif.in_b     = rnd();
            step();
        end
        sif.in_valid = 1'b0;
        repeat (LAT + 5) step();
        for (int i = 0; i < 50; i++) begin
            sif.in_valid = 1'b1;
            sif.in_a     = rnd();
            sif.in_b     = rnd();
            step();
        end
        sif.in_valid = 1'b0;
        step();
        chk("mrst_pre_valid", Z_W'(sif.out_valid), Z_W'(1));
        rstn = 1'b0;
        #1;
        chk("mrst_out_valid", Z_W'(sif.out_valid), '0);
        chk("mrst_used", Z_W'(used), '0);
        chk("mrst_in_ready", Z_W'(sif.in_ready), '0);
        step();
        rstn          = 1'b1;
        sif.out_ready = 1'b1;
        hi = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (sif.out_valid) hi++;
            step();
        end
        chk("mrst_no_stale", Z_W'(hi), '0);
        chk("mrst_err", Z_W'(err_overflow), '0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
